// File: rtl/axis_egress_drop_fifo.sv
// ---------------------------------------------------------------------------
// axis_egress_drop_fifo
//
// Store-and-forward AXI-stream frame FIFO that sits just upstream of the
// egress boundary. A frame becomes visible on the m_* side only after its
// last beat has been accepted without an error flag. Errored frames and
// frames that do not fit in the buffer are discarded. Upstream is never
// back-pressured outside reset, so a stalled link drops frames rather than
// stalling the pipeline.
//
// Ports
//   clk, rst          single clock, synchronous active-high reset
//   s_tdata/tvalid/tready/tlast/tuser   upstream AXI-stream slave
//                     (tuser[0] on the last beat = frame error)
//   m_tdata/tvalid/tready/tlast/tuser   downstream AXI-stream master
//                     (tuser[0] is always 0 on released frames)
//   frame_count       committed frames, saturating
//   drop_count        dropped frames, saturating
//
// Build option
//   AXIS_DROP_FIFO_STATS_EN  defined: frame_count/drop_count are live
//                            registers. Undefined: both ports tied to 0.
//
// Write FSM
//   state     | meaning
//   ST_ACCEPT | beats are stored speculatively at wr_cur
//   ST_DROP   | current frame overflowed; discard until its last beat
// ---------------------------------------------------------------------------
module axis_egress_drop_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tlast,
    input  logic [USER_WIDTH-1:0] s_tuser,

    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic [USER_WIDTH-1:0] m_tuser,

    output logic [CNT_WIDTH-1:0]  frame_count,
    output logic [CNT_WIDTH-1:0]  drop_count
);

    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int PTR_W   = ADDR_W + 1;
    localparam int ENTRY_W = DATA_WIDTH + USER_WIDTH + 1;

    // Bit 0 of tuser is the error flag; it is cleared in storage because only
    // error-free frames are ever released.
    localparam logic [USER_WIDTH-1:0] USER_MASK = ~USER_WIDTH'(1);

    typedef enum logic {
        ST_ACCEPT = 1'b0,
        ST_DROP   = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [PTR_W-1:0]   r_wr_commit;
    logic [PTR_W-1:0]   r_wr_cur;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [ENTRY_W-1:0] r_mem [DEPTH];

    logic               w_s_tready;
    logic               w_m_tvalid;
    logic               w_wr_fire;
    logic               w_rd_fire;
    logic               w_full;
    logic               w_err;
    logic [USER_WIDTH-1:0] w_user_store;

    logic               w_mem_we;
    logic               w_wr_advance;
    logic               w_wr_rewind;
    logic               w_commit;
    logic               w_drop_inc;

    // -----------------------------------------------------------------------
    // Handshake and occupancy
    // -----------------------------------------------------------------------
    assign w_s_tready   = ~rst;
    assign w_m_tvalid   = ~rst && (r_rd_ptr != r_wr_commit);
    assign w_wr_fire    = s_tvalid && w_s_tready;
    assign w_rd_fire    = w_m_tvalid && m_tready;
    assign w_err        = s_tuser[0];
    assign w_user_store = s_tuser & USER_MASK;

    // Occupancy includes the speculative frame. The pre-edge read pointer is
    // used, so a same-cycle read does not make room for this write.
    assign w_full = ((r_wr_cur - r_rd_ptr) == PTR_W'(DEPTH));

    // -----------------------------------------------------------------------
    // Write FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACCEPT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Write FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACCEPT: begin
                if (w_wr_fire && w_full && !s_tlast) begin
                    w_state_nxt = ST_DROP;
                end
            end
            ST_DROP: begin
                if (w_wr_fire && s_tlast) begin
                    w_state_nxt = ST_ACCEPT;
                end
            end
            default: w_state_nxt = ST_ACCEPT;
        endcase
    end

    // -----------------------------------------------------------------------
    // Write FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        w_mem_we     = 1'b0;
        w_wr_advance = 1'b0;
        w_wr_rewind  = 1'b0;
        w_commit     = 1'b0;
        w_drop_inc   = 1'b0;
        case (r_state)
            ST_ACCEPT: begin
                if (w_wr_fire) begin
                    if (w_full) begin
                        w_wr_rewind = 1'b1;
                        w_drop_inc  = s_tlast;
                    end else begin
                        w_mem_we = 1'b1;
                        if (s_tlast && !w_err) begin
                            w_wr_advance = 1'b1;
                            w_commit     = 1'b1;
                        end else if (s_tlast) begin
                            w_wr_rewind = 1'b1;
                            w_drop_inc  = 1'b1;
                        end else begin
                            w_wr_advance = 1'b1;
                        end
                    end
                end
            end
            ST_DROP: begin
                // wr_cur was already rewound when the overflow was detected.
                w_drop_inc = w_wr_fire && s_tlast;
            end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Pointers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_commit <= '0;
            r_wr_cur    <= '0;
            r_rd_ptr    <= '0;
        end else begin
            if (w_wr_rewind) begin
                r_wr_cur <= r_wr_commit;
            end else if (w_wr_advance) begin
                r_wr_cur <= r_wr_cur + PTR_W'(1);
            end
            if (w_commit) begin
                r_wr_commit <= r_wr_cur + PTR_W'(1);
            end
            if (w_rd_fire) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Storage: {last, user, data}
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_wr_cur[ADDR_W-1:0]] <= {s_tlast, w_user_store, s_tdata};
        end
    end

    assign {m_tlast, m_tuser, m_tdata} = r_mem[r_rd_ptr[ADDR_W-1:0]];
    assign m_tvalid = w_m_tvalid;
    assign s_tready = w_s_tready;

    // -----------------------------------------------------------------------
    // Statistics
    // -----------------------------------------------------------------------
`ifdef AXIS_DROP_FIFO_STATS_EN
    logic [CNT_WIDTH-1:0] r_frame_count;
    logic [CNT_WIDTH-1:0] r_drop_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_count <= '0;
            r_drop_count  <= '0;
        end else begin
            if (w_commit && (r_frame_count != '1)) begin
                r_frame_count <= r_frame_count + CNT_WIDTH'(1);
            end
            if (w_drop_inc && (r_drop_count != '1)) begin
                r_drop_count <= r_drop_count + CNT_WIDTH'(1);
            end
        end
    end

    assign frame_count = r_frame_count;
    assign drop_count  = r_drop_count;
`else
    logic w_unused_stats;
    assign w_unused_stats = w_drop_inc;
    assign frame_count    = '0;
    assign drop_count     = '0;
`endif

endmodule

// File: tb/tb_axis_egress_drop_fifo.sv
// ---------------------------------------------------------------------------
// tb_axis_egress_drop_fifo
//
// Self-checking bench for axis_egress_drop_fifo (default parameters).
// Inputs are driven 1 time unit after the rising edge; the DUT is observed
// on the falling edge. A reference model of the frame FIFO pushes each
// committed frame into a scoreboard queue; the monitor pops and compares on
// every output handshake. Counter expectations follow the
// AXIS_DROP_FIFO_STATS_EN build option (0 when stats are not built).
// ---------------------------------------------------------------------------
module tb_axis_egress_drop_fifo;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst;
    logic [63:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic [0:0]  s_tuser;
    logic [63:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic [0:0]  m_tuser;
    logic [31:0] frame_count;
    logic [31:0] drop_count;

    axis_egress_drop_fifo #(
        .DATA_WIDTH (64),
        .USER_WIDTH (1),
        .DEPTH      (DEPTH),
        .CNT_WIDTH  (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_tdata     (s_tdata),
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .s_tlast     (s_tlast),
        .s_tuser     (s_tuser),
        .m_tdata     (m_tdata),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tlast     (m_tlast),
        .m_tuser     (m_tuser),
        .frame_count (frame_count),
        .drop_count  (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input int v);
`ifdef AXIS_DROP_FIFO_STATS_EN
        return 32'(v);
`else
        return (v == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    // -----------------------------------------------------------------------
    // Reference model + scoreboard
    // -----------------------------------------------------------------------
    typedef struct {
        logic [63:0] d;
        logic        l;
    } beat_t;

    beat_t q_exp[$];
    beat_t q_pend[$];
    bit    mdl_drop = 1'b0;
    int    n_out    = 0;
    int    n_last   = 0;

    always @(negedge clk) begin
        bit    full;
        beat_t b;
        if (rst) begin
            q_exp.delete();
            q_pend.delete();
            mdl_drop = 1'b0;
        end else begin
            full = ((q_exp.size() + q_pend.size()) == DEPTH);
            check("m_tvalid", {63'd0, m_tvalid}, {63'd0, q_exp.size() != 0});
            if (s_tvalid) check("s_tready", {63'd0, s_tready}, 64'd1);
            if (m_tvalid && m_tready && q_exp.size() != 0) begin
                b = q_exp.pop_front();
                check("m_tdata", m_tdata, b.d);
                check("m_tlast", {63'd0, m_tlast}, {63'd0, b.l});
                check("m_tuser", {63'd0, m_tuser}, 64'd0);
                n_out++;
                if (m_tlast) n_last++;
            end
            if (s_tvalid && s_tready) begin
                b.d = s_tdata;
                b.l = s_tlast;
                if (mdl_drop) begin
                    if (s_tlast) mdl_drop = 1'b0;
                end else if (full) begin
                    q_pend.delete();
                    if (!s_tlast) mdl_drop = 1'b1;
                end else begin
                    q_pend.push_back(b);
                    if (s_tlast) begin
                        if (!s_tuser[0]) begin
                            foreach (q_pend[i]) q_exp.push_back(q_pend[i]);
                        end
                        q_pend.delete();
                    end
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Drivers
    // -----------------------------------------------------------------------
    bit toggle_rdy = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle_rdy) m_tready = ~m_tready;
    endtask

    task automatic send_beat(input logic [63:0] d, input bit last, input bit err);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = last;
        s_tuser  = (err && last) ? 1'b1 : 1'b0;
        tick();
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_frame(input int len, input logic [63:0] base, input bit err, input int gap);
        for (int i = 0; i < len; i++) begin
            send_beat(base + 64'(i), i == len - 1, err);
        end
        idle(gap);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_tvalid = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((q_exp.size() != 0 || m_tvalid) && n < limit) begin
            tick();
            n++;
        end
        check("drain_q_size", 64'(q_exp.size()), 64'd0);
        check("drain_m_tvalid", {63'd0, m_tvalid}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // -----------------------------------------------------------------------
    // Test sequence
    // -----------------------------------------------------------------------
    initial begin
        int out0;
        int last0;

        rst      = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
        m_tready = 1'b0;

        // Reset state
        tick();
        check("rst_s_tready", {63'd0, s_tready}, 64'd0);
        check("rst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
        rst = 1'b0;
        tick();
        check("post_rst_s_tready", {63'd0, s_tready}, 64'd1);
        check("post_rst_frame_count", 64'(frame_count), 64'(cnt_exp(0)));
        check("post_rst_drop_count", 64'(drop_count), 64'(cnt_exp(0)));

        // 1: simple 3-beat frame, check latency
        m_tready = 1'b1;
        send_beat(64'h11, 1'b0, 1'b0);
        send_beat(64'h22, 1'b0, 1'b0);
        check("t1_not_yet_valid", {63'd0, m_tvalid}, 64'd0);
        send_beat(64'h33, 1'b1, 1'b0);
        check("t1_latency_valid", {63'd0, m_tvalid}, 64'd1);
        check("t1_first_beat", m_tdata, 64'h11);
        idle(1);
        drain(50);
        check("t1_frame_count", 64'(frame_count), 64'(cnt_exp(1)));

        // 2: errored frame dropped, good frame passes
        do_reset();
        m_tready = 1'b1;
        send_frame(4, 64'h2000, 1'b1, 3);
        check("t2_err_drop_count", 64'(drop_count), 64'(cnt_exp(1)));
        send_frame(2, 64'h2100, 1'b0, 2);
        drain(50);
        check("t2_frame_count", 64'(frame_count), 64'(cnt_exp(1)));
        check("t2_drop_count", 64'(drop_count), 64'(cnt_exp(1)));

        // 3: oversize frame always dropped
        do_reset();
        m_tready = 1'b0;
        send_frame(20, 64'h3000, 1'b0, 3);
        check("t3_drop_count", 64'(drop_count), 64'(cnt_exp(1)));
        check("t3_frame_count", 64'(frame_count), 64'(cnt_exp(0)));
        check("t3_empty", {63'd0, m_tvalid}, 64'd0);

        // 4: fill with two 8-beat frames, third frame overflows
        do_reset();
        m_tready = 1'b0;
        send_frame(8, 64'h4000, 1'b0, 0);
        send_frame(8, 64'h4100, 1'b0, 0);
        send_frame(3, 64'h4200, 1'b0, 2);
        check("t4_drop_count", 64'(drop_count), 64'(cnt_exp(1)));
        check("t4_frame_count", 64'(frame_count), 64'(cnt_exp(2)));
        out0  = n_out;
        last0 = n_last;
        m_tready = 1'b1;
        drain(100);
        check("t4_beats_out", 64'(n_out - out0), 64'd16);
        check("t4_tlast_pulses", 64'(n_last - last0), 64'd2);

        // 5: 40 back-to-back-ish frames with toggling ready, pointer wrap
        do_reset();
        m_tready   = 1'b1;
        toggle_rdy = 1'b1;
        out0 = n_out;
        for (int f = 0; f < 40; f++) begin
            send_frame(5, 64'h5000 + 64'(f * 16), 1'b0, 12);
        end
        drain(100);
        toggle_rdy = 1'b0;
        check("t5_beats_out", 64'(n_out - out0), 64'd200);
        check("t5_frame_count", 64'(frame_count), 64'(cnt_exp(40)));
        check("t5_drop_count", 64'(drop_count), 64'(cnt_exp(0)));

        // 6: reset mid-frame with a committed frame queued
        do_reset();
        m_tready = 1'b0;
        send_frame(3, 64'h6000, 1'b0, 1);
        check("t6_queued_valid", {63'd0, m_tvalid}, 64'd1);
        send_beat(64'h6100, 1'b0, 1'b0);
        send_beat(64'h6101, 1'b0, 1'b0);
        s_tvalid = 1'b0;
        rst = 1'b1;
        #1;
        check("t6_rst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
        check("t6_rst_s_tready", {63'd0, s_tready}, 64'd0);
        tick();
        tick();
        check("t6_rst_m_tvalid_hold", {63'd0, m_tvalid}, 64'd0);
        rst = 1'b0;
        tick();
        check("t6_post_s_tready", {63'd0, s_tready}, 64'd1);
        check("t6_post_empty", {63'd0, m_tvalid}, 64'd0);
        check("t6_post_frame_count", 64'(frame_count), 64'(cnt_exp(0)));
        check("t6_post_drop_count", 64'(drop_count), 64'(cnt_exp(0)));
        m_tready = 1'b1;
        out0 = n_out;
        send_frame(4, 64'h6200, 1'b0, 2);
        drain(50);
        check("t6_next_beats", 64'(n_out - out0), 64'd4);
        check("t6_next_frame_count", 64'(frame_count), 64'(cnt_exp(1)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
